// File: rtl/cpu_types_pkg.sv
// Shared CPU-side types: data word, memory arbiter state encoding and the
// poison word returned when a RAM access is force-completed.
package cpu_types_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DATA  = 2'd1,
    INSTR = 2'd2
  } arb_state_t;

  localparam word_t BAD_WORD = 32'hBAD1_BAD1;

endpackage

// File: rtl/arb_timer.sv
// Watchdog counter for one RAM access: cleared on access start, counts
// cycles without ack, flags the cycle in which the count sits at TIMEOUT-1.
module arb_timer #(
  parameter int TIMEOUT = 255,
  parameter int CNT_W   = 8
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clr_i,
  input  logic en_i,
  output logic expired_o
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             exp_q, exp_d;

  // expired is registered so the parent sees it in the same cycle the count hits LAST
  always_comb begin
    cnt_d = cnt_q;
    exp_d = exp_q;
    if (clr_i) begin
      cnt_d = '0;
      exp_d = (LAST == '0);
    end else if (en_i) begin
      cnt_d = cnt_q + 1'b1;
      exp_d = ((cnt_q + 1'b1) == LAST);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
      exp_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      exp_q <= exp_d;
    end
  end

  assign expired_o = exp_q;

endmodule

// File: rtl/mem_arbiter.sv
// Serialises instruction and data requests onto one single-ported RAM and
// returns iHit/dHit completion pulses; a watchdog force-completes stuck accesses.
module mem_arbiter
  import cpu_types_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 255,
  parameter int CNT_W   = 8
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              iMemRe,
  input  logic [ADDR_W-1:0] iaddr,
  input  logic              dMemRe,
  input  logic              dMemWr,
  input  logic [ADDR_W-1:0] daddr,
  input  logic [DATA_W-1:0] dstore,
  output logic              iHit,
  output logic [DATA_W-1:0] iload,
  output logic              dHit,
  output logic [DATA_W-1:0] dload,
  output logic              ram_ren,
  output logic              ram_wen,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata,
  input  logic              ram_ack,
  output logic              err
);

  localparam logic [DATA_W-1:0] BAD = DATA_W'(BAD_WORD);

  arb_state_t        state_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic              wr_q;
  logic              err_q;

  logic busy, dreq, accept, expired, ack_done, tmo_done, done;

  assign busy     = (state_q != IDLE);
  assign dreq     = dMemRe | dMemWr;
  assign accept   = (state_q == IDLE) & (dreq | iMemRe);
  assign ack_done = busy & ram_ack;
  // ack in the expiry cycle wins: normal completion, no error
  assign tmo_done = busy & ~ram_ack & expired;
  assign done     = ack_done | tmo_done;

  arb_timer #(.TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) u_timer (
    .clk_i     (CLK),
    .rst_i     (RST),
    .clr_i     (accept),
    .en_i      (busy & ~ram_ack),
    .expired_o (expired)
  );

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      wr_q    <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (dreq) begin
            state_q <= DATA;
            addr_q  <= daddr;
            wdata_q <= dstore;
            wr_q    <= dMemWr;
          end else if (iMemRe) begin
            state_q <= INSTR;
            addr_q  <= iaddr;
            wr_q    <= 1'b0;
          end
        end
        default: begin
          if (done)     state_q <= IDLE;
          if (tmo_done) err_q   <= 1'b1;
        end
      endcase
    end
  end

  assign iHit = (state_q == INSTR) & done;
  assign dHit = (state_q == DATA)  & done;

  assign iload = iHit ? (ram_ack ? ram_rdata : BAD) : '0;
  assign dload = dHit ? (ram_ack ? (wr_q ? '0 : ram_rdata) : BAD) : '0;

  assign ram_ren   = busy & ~wr_q;
  assign ram_wen   = busy & wr_q;
  assign ram_addr  = busy ? addr_q : '0;
  assign ram_wdata = (busy & wr_q) ? wdata_q : '0;
  assign err       = err_q;

endmodule
